bias_loader: RTL and testbench
==============================

Name: bias_loader

Overview:
- Writer side of the per-neuron bias store: accepts a valid/ready stream of bias words and distributes them, in order, to `num_neurons` bias memories.
- Drives a shared `bias_data` bus plus a one-hot `write_en_vec` (one bit per neuron's `write_en`).
- Sits between the host/config interface and the neuron array; used only in non-pretrained builds.

Parameters:
- data_bits, 16, width of one bias word (matches the bias memory `bias_in` width).
- num_neurons, 8, number of bias memories fed; legal range 2..256.
- idx_bits, $clog2(num_neurons), width of the neuron index/count (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a load sequence (sampled in IDLE or DONE only).
- abort  input  1  cancel an in-progress load.
- s_valid  input  1  upstream bias word valid.
- s_data  input  data_bits  upstream bias word (two's complement, passed through unmodified).
- s_ready  output  1  loader can accept a word this cycle.
- bias_data  output  data_bits  shared data bus to every bias memory `bias_in`.
- write_en_vec  output  num_neurons  one-hot write enables; bit i goes to neuron i `write_en`.
- busy  output  1  high in LOAD.
- done  output  1  all num_neurons words written; sticky until next start/reset.
- loaded_count  output  idx_bits+1  number of words accepted in the current/last sequence.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - bias_data=0, write_en_vec=0, s_ready=0, busy=0, done=0, loaded_count=0, idx=0.
- States: IDLE, LOAD, DONE.
  - s_ready = (state==LOAD), combinational from state.
  - busy = (state==LOAD).
  - done = (state==DONE).
- IDLE:
  - start=1 -> LOAD next cycle; idx=0; loaded_count=0.
  - abort is ignored.
- LOAD:
  - A word is accepted when s_valid && s_ready at a rising edge.
  - At the accepting edge:
    - bias_data <= s_data.
    - write_en_vec <= one-hot(idx).
    - idx <= idx+1.
    - loaded_count <= loaded_count+1.
  - write_en_vec is a single-cycle pulse. It clears at the next edge unless another word is accepted there.
  - Back-to-back accepts are allowed: one word per cycle, full throughput.
  - Latency: word accepted at edge k appears on bias_data/write_en_vec during cycle k..k+1. The bias memory captures it at edge k+1.
  - bias_data holds its last value when no write occurs.
  - Accepting the word with idx==num_neurons-1 -> DONE at the same edge. The final write pulse is still issued in the following cycle.
  - No wrap-around: idx never exceeds num_neurons-1.
  - start while in LOAD is ignored.
  - abort=1 -> IDLE at the next edge, done stays 0, loaded_count holds the partial count.
  - abort and accept on the same edge: abort wins; the word is not written and write_en_vec stays 0.
- DONE:
  - s_ready=0; words presented are not accepted (upstream must hold them).
  - start=1 -> LOAD with idx=0, loaded_count=0, done deasserted.
  - abort is ignored.
- Reset mid-sequence:
  - All outputs return to reset values asynchronously, including any in-flight write pulse.
  - Partially loaded memories keep their contents (not this block's concern).
- Invariant: popcount(write_en_vec) ≤ 1 in every cycle.

Test Plan:
- Reset then start, stream 8 words 0x0001..0x0008 with s_valid held high (num_neurons=8) -> write_en_vec pulses 0x01,0x02,…,0x80 on consecutive cycles with bias_data=0x0001..0x0008; done=1 after the last; loaded_count=8.
- Same stream with s_valid toggling 1/0 -> each write_en_vec bit pulses exactly once; no pulse in gap cycles; bias_data holds between writes; done after 8 accepts.
- Start, accept 3 words (0xFFFF, 0x8000, 0x7FFF), then abort -> neurons 0..2 written with those values; state IDLE; done=0; loaded_count=3.
- Abort asserted on the same edge as 4th accept -> no write pulse for bit 3; loaded_count=3; IDLE.
- In DONE, hold s_valid=1 with 0x1234 for 5 cycles -> s_ready=0, write_en_vec=0 throughout. Then start -> reload begins with write_en_vec=0x01, bias_data=0x1234.
- Assert reset asynchronously mid-cycle while write_en_vec=0x04 -> write_en_vec, bias_data, busy, loaded_count go to 0 before the next clock edge; state IDLE.

Source files
------------

// File: rtl/bias_loader.sv
// Writer side of the per-neuron bias store. It streams bias words in order into
// num_neurons bias memories over a shared data bus and one-hot write enables.
module bias_loader #(
  parameter int unsigned data_bits   = 16,
  parameter int unsigned num_neurons = 8,
  parameter int unsigned idx_bits    = $clog2(num_neurons)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   s_valid,
  input  logic [data_bits-1:0]   s_data,
  output logic                   s_ready,
  output logic [data_bits-1:0]   bias_data,
  output logic [num_neurons-1:0] write_en_vec,
  output logic                   busy,
  output logic                   done,
  output logic [idx_bits:0]      loaded_count
);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_load = 2'd1,
    st_done = 2'd2
  } state_t;

  localparam logic [idx_bits-1:0]    last_idx  = idx_bits'(num_neurons - 1);
  localparam logic [num_neurons-1:0] first_hot = num_neurons'(1);

  state_t                 state_q, state_d;
  logic [idx_bits-1:0]    idx_q, idx_d;
  logic [idx_bits:0]      count_d;
  logic [data_bits-1:0]   bias_d;
  logic [num_neurons-1:0] wen_d;

  // State and datapath registers; reset also kills any in-flight write pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= st_idle;
      idx_q        <= '0;
      loaded_count <= '0;
      bias_data    <= '0;
      write_en_vec <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      loaded_count <= count_d;
      bias_data    <= bias_d;
      write_en_vec <= wen_d;
    end
  end

  // Next state and datapath; abort has priority over a same-edge accept.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = loaded_count;
    bias_d  = bias_data;
    wen_d   = '0;
    case (state_q)
      st_idle, st_done: begin
        if (start) begin
          state_d = st_load;
          idx_d   = '0;
          count_d = '0;
        end
      end
      st_load: begin
        if (abort) begin
          state_d = st_idle;
        end else if (s_valid) begin
          bias_d  = s_data;
          wen_d   = first_hot << idx_q;
          count_d = loaded_count + 1'b1;
          if (idx_q == last_idx) begin
            state_d = st_done;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = st_idle;
    endcase
  end

  // Status decoded straight from the state register.
  assign s_ready = (state_q == st_load);
  assign busy    = (state_q == st_load);
  assign done    = (state_q == st_done);

endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader: directed vector table, corner sequences,
// and random traffic against a word-counting reference model.
`timescale 1ns/1ps
module tb_bias_loader;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [15:0] bias_data;
  logic [7:0]  write_en_vec;
  logic        busy, done;
  logic [3:0]  loaded_count;

  int total = 0;
  int bad   = 0;

  bias_loader #(.data_bits(16), .num_neurons(N)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .bias_data(bias_data), .write_en_vec(write_en_vec),
    .busy(busy), .done(done), .loaded_count(loaded_count)
  );

  always #5 clk = ~clk;

  // Bias memories as the neurons would see them.
  logic [15:0] mem [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (write_en_vec[i]) mem[i] <= bias_data;
  end

  // Reference model: a loading flag plus a count of accepted words.
  bit          m_loading, m_done;
  int          m_count;
  logic [7:0]  m_wen;
  logic [15:0] m_bias;

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_count = 0; m_wen = '0; m_bias = '0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit v, input logic [15:0] d);
    m_wen = '0;
    if (m_loading) begin
      if (ab) begin
        m_loading = 0;
      end else if (v) begin
        m_wen   = 8'(1 << m_count);
        m_bias  = d;
        m_count = m_count + 1;
        if (m_count == N) begin
          m_loading = 0;
          m_done    = 1;
        end
      end
    end else if (st) begin
      m_loading = 1;
      m_done    = 0;
      m_count   = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("write_en_vec", 32'(write_en_vec), 32'(m_wen));
    chk("bias_data", 32'(bias_data), 32'(m_bias));
    chk("busy", 32'(busy), 32'(m_loading));
    chk("done", 32'(done), 32'(m_done));
    chk("loaded_count", 32'(loaded_count), 32'(m_count));
    chk("onehot", 32'($countones(write_en_vec) <= 1), 32'(1));
  endtask

  // One clock with the given inputs, checked against the model.
  task automatic cycle(input bit st, input bit ab, input bit v, input logic [15:0] d);
    start = st; abort = ab; s_valid = v; s_data = d;
    #1;
    chk("s_ready", 32'(s_ready), 32'(m_loading));
    @(posedge clk);
    model_edge(st, ab, v, d);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; abort = 0; s_valid = 0; s_data = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          st, ab, v;
    logic [15:0] d;
    logic [7:0]  wen;
    logic [15:0] bias;
    bit          busy, done, ready;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[16];
  int   pulses;
  logic [7:0] seen;

  initial begin
    // Full stream, then DONE holding a presented word, then restart.
    tbl[0] = '{1, 0, 0, 16'h0000, 8'h00, 16'h0000, 1, 0, 1, 4'd0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{0, 0, 1, 16'(i), 8'(1 << (i - 1)), 16'(i), i < 8, i == 8, i < 8, 4'(i)};
    for (int i = 9; i <= 13; i++)
      tbl[i] = '{0, 0, 1, 16'h1234, 8'h00, 16'h0008, 0, 1, 0, 4'd8};
    tbl[14] = '{1, 0, 1, 16'h1234, 8'h00, 16'h0008, 1, 0, 1, 4'd0};
    tbl[15] = '{0, 0, 1, 16'h1234, 8'h01, 16'h1234, 1, 0, 1, 4'd1};

    do_reset();
    chk("rst_wen", 32'(write_en_vec), 32'h0);
    chk("rst_bias", 32'(bias_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h0);
    chk("rst_count", 32'(loaded_count), 32'h0);

    for (int r = 0; r < 16; r++) begin
      start = tbl[r].st; abort = tbl[r].ab; s_valid = tbl[r].v; s_data = tbl[r].d;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_wen", r), 32'(write_en_vec), 32'(tbl[r].wen));
      chk($sformatf("tbl%0d_bias", r), 32'(bias_data), 32'(tbl[r].bias));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
      chk($sformatf("tbl%0d_done", r), 32'(done), 32'(tbl[r].done));
      chk($sformatf("tbl%0d_ready", r), 32'(s_ready), 32'(tbl[r].ready));
      chk($sformatf("tbl%0d_cnt", r), 32'(loaded_count), 32'(tbl[r].cnt));
    end

    // s_valid toggling: every neuron pulsed exactly once, gaps silent.
    do_reset();
    cycle(1, 0, 0, 16'h0);
    pulses = 0; seen = '0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, (i % 2) == 0, (i % 2) == 0 ? 16'(16'h0100 + i) : 16'hDEAD);
      if (write_en_vec != 0) pulses++;
      seen = seen | write_en_vec;
    end
    chk("toggle_pulses", 32'(pulses), 32'd8);
    chk("toggle_seen", 32'(seen), 32'hFF);
    chk("toggle_done", 32'(done), 32'h1);
    chk("toggle_mem7", 32'(mem[7]), 32'h010E);

    // Three words then abort.
    do_reset();
    cycle(1, 0, 0, 16'h0);
    cycle(0, 0, 1, 16'hFFFF);
    cycle(0, 0, 1, 16'h8000);
    cycle(0, 0, 1, 16'h7FFF);
    cycle(0, 1, 0, 16'h0);
    cycle(0, 0, 0, 16'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_count", 32'(loaded_count), 32'd3);
    chk("abort_mem0", 32'(mem[0]), 32'hFFFF);
    chk("abort_mem1", 32'(mem[1]), 32'h8000);
    chk("abort_mem2", 32'(mem[2]), 32'h7FFF);

    // Abort on the same edge as the fourth accept.
    do_reset();
    cycle(1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 16'(16'h0A00 + i));
    cycle(0, 1, 1, 16'h4444);
    chk("abort_acc_wen", 32'(write_en_vec), 32'h0);
    chk("abort_acc_count", 32'(loaded_count), 32'd3);
    chk("abort_acc_busy", 32'(busy), 32'h0);
    cycle(0, 0, 1, 16'h5555);
    chk("abort_acc_wen2", 32'(write_en_vec), 32'h0);

    // Asynchronous reset while the third write pulse is out.
    do_reset();
    cycle(1, 0, 0, 16'h0);
    cycle(0, 0, 1, 16'h0011);
    cycle(0, 0, 1, 16'h0022);
    cycle(0, 0, 1, 16'h0033);
    chk("pre_rst_wen", 32'(write_en_vec), 32'h04);
    #2 reset = 1'b1;
    #1;
    chk("arst_wen", 32'(write_en_vec), 32'h0);
    chk("arst_bias", 32'(bias_data), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_count", 32'(loaded_count), 32'h0);
    chk("arst_ready", 32'(s_ready), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(7) == 0, $urandom_range(15) == 0,
            $urandom_range(1) == 1, 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
